// File: rtl/mips32_trace_pkg.sv
// Shared types and widths for the mips32 result tracer.
package mips32_trace_pkg;

    localparam int SAMPLE_W = 32;
    localparam int TSTAMP_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        POST,
        READOUT
    } trace_state_e;

endpackage

// File: rtl/mips32_trace_ram.sv
// DEPTH x W simple dual-port trace RAM: synchronous write, registered read
// with write-first bypass when both ports address the same entry.
module mips32_trace_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;
    logic [W-1:0] rdata_d;

    // NOTE: the storage array has no reset so it can map onto RAM macros;
    // only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips32_result_tracer.sv
// Circular trace of the mips32 result bus: trigger, post-trigger window, oldest-first drain.
// Define MIPS32_TRACE_TSTAMP_EN to store a 16-bit cycle stamp with every entry.
module mips32_result_tracer
    import mips32_trace_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int POST_SAMPLES = 2,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arm,
    input  logic                abort,
    input  logic                res_valid,
    input  logic [SAMPLE_W-1:0] result,
    input  logic [SAMPLE_W-1:0] trig_value,
    input  logic [SAMPLE_W-1:0] trig_mask,
    input  logic                rd_ready,
    output logic                rd_valid,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                busy,
    output logic                triggered,
    output logic                done,
    output logic [AW:0]         sample_count
`ifdef MIPS32_TRACE_TSTAMP_EN
    ,
    output logic [TSTAMP_W-1:0] rd_tstamp
`endif
);

`ifdef MIPS32_TRACE_TSTAMP_EN
    localparam int W = SAMPLE_W + TSTAMP_W;
`else
    localparam int W = SAMPLE_W;
`endif
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    trace_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic          done_q, done_d;

    logic          trig_hit;
    logic          wr_en;
    logic          enter_readout;
    logic          rd_en;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  ram_rdata;

    assign trig_hit = res_valid && (((result ^ trig_value) & trig_mask) == '0);

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        remaining_d   = remaining_q;
        post_cnt_d    = post_cnt_q;
        done_d        = 1'b0;
        wr_en         = 1'b0;
        enter_readout = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d  = ARMED;
                        wr_ptr_d = '0;
                        count_d  = '0;
                    end
                end
                ARMED: begin
                    if (res_valid) begin
                        wr_en = 1'b1;
                        if (trig_hit) begin
                            if (POST_SAMPLES == 0) begin
                                enter_readout = 1'b1;
                            end else begin
                                post_cnt_d = AW'(POST_SAMPLES);
                                state_d    = POST;
                            end
                        end
                    end
                end
                POST: begin
                    if (res_valid) begin
                        wr_en      = 1'b1;
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_q == AW'(1)) begin
                            enter_readout = 1'b1;
                        end
                    end
                end
                READOUT: begin
                    if (rd_valid && rd_ready) begin
                        rd_ptr_d    = rd_ptr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == (AW+1)'(1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q != FULL) begin
                    count_d = count_q + 1'b1;
                end
            end

            // A full buffer has wrapped, so the oldest entry sits at the write pointer.
            if (enter_readout) begin
                state_d     = READOUT;
                rd_ptr_d    = (count_d == FULL) ? wr_ptr_d : '0;
                remaining_d = count_d;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            post_cnt_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            post_cnt_q  <= post_cnt_d;
            done_q      <= done_d;
        end
    end

`ifdef MIPS32_TRACE_TSTAMP_EN
    logic [TSTAMP_W-1:0] stamp_q, stamp_d;

    always_comb begin
        stamp_d = stamp_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stamp_q <= '0;
        end else begin
            stamp_q <= stamp_d;
        end
    end

    assign wr_data   = {stamp_q, result};
    assign rd_tstamp = ram_rdata[SAMPLE_W +: TSTAMP_W];
`else
    assign wr_data = result;
`endif

    // Read the entry that will be current next cycle so rd_data is ready with rd_valid.
    assign rd_en = (state_d == READOUT);

    mips32_trace_ram #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_ptr_d),
        .rdata (ram_rdata)
    );

    assign rd_data      = ram_rdata[SAMPLE_W-1:0];
    assign rd_valid     = (state_q == READOUT) && (remaining_q != '0);
    assign busy         = (state_q != IDLE);
    assign triggered    = (state_q == POST) || (state_q == READOUT);
    assign done         = done_q;
    assign sample_count = count_q;

endmodule

// File: tb/tb_mips32_result_tracer.sv
// Scoreboard bench for mips32_result_tracer (DEPTH=8, POST_SAMPLES=2).
module tb_mips32_result_tracer;

    logic        clk = 1'b0;
    logic        reset, arm, abort, res_valid, rd_ready;
    logic [31:0] result, trig_value, trig_mask;
    logic        rd_valid, busy, triggered, done;
    logic [31:0] rd_data;
    logic [3:0]  sample_count;
`ifdef MIPS32_TRACE_TSTAMP_EN
    logic [15:0] rd_tstamp;
`endif

    typedef struct {
        logic [31:0] data;
        logic [15:0] stamp;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    mips32_result_tracer #(
        .DEPTH        (8),
        .POST_SAMPLES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .abort        (abort),
        .res_valid    (res_valid),
        .result       (result),
        .trig_value   (trig_value),
        .trig_mask    (trig_mask),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done),
        .sample_count (sample_count)
`ifdef MIPS32_TRACE_TSTAMP_EN
        ,
        .rd_tstamp    (rd_tstamp)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] data, input logic [15:0] stamp);
        exp_t e;
        e.data  = data;
        e.stamp = stamp;
        exp_q.push_back(e);
    endtask

    task automatic do_arm(input logic [31:0] stray);
        arm       = 1'b1;
        res_valid = 1'b1;
        result    = stray;
        step();
        arm       = 1'b0;
        res_valid = 1'b0;
    endtask

    task automatic feed(input logic [31:0] v);
        res_valid = 1'b1;
        result    = v;
        step();
        res_valid = 1'b0;
    endtask

    // Drains with rd_ready low for stall_len cycles from cycle stall_at, then closes out.
    task automatic drain(input string name, input int stall_at, input int stall_len);
        bit got;
        int done_before;
        got         = 1'b0;
        done_before = done_cnt;
        for (int i = 0; i < 200; i++) begin
            rd_ready = !(i >= stall_at && i < stall_at + stall_len);
            step();
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        rd_ready = 1'b0;
        check({name, "_done_seen"}, 32'(got), 32'd1);
        step();
        check({name, "_done_width"}, 32'(done), 32'd0);
        check({name, "_done_count"}, 32'(done_cnt - done_before), 32'd1);
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin
        logic        stall_prev;
        logic [31:0] stall_data;
        exp_t        e;
        stall_prev = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (stall_prev) begin
                check("stall_valid", 32'(rd_valid), 32'd1);
                check("stall_data", rd_data, stall_data);
            end
            stall_prev = rd_valid && !rd_ready;
            stall_data = rd_data;
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rd_extra: got 0x%08h, want no sample", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", rd_data, e.data);
`ifdef MIPS32_TRACE_TSTAMP_EN
                    check("rd_tstamp", 32'(rd_tstamp), 32'(e.stamp));
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int done_before;
        reset = 1'b1; arm = 1'b0; abort = 1'b0; res_valid = 1'b0; rd_ready = 1'b0;
        result = '0; trig_value = '0; trig_mask = '1;
        step(); step();
        reset = 1'b0;

        // Reset in the middle of a capture
        trig_value = 32'hFFFF_0000;
        do_arm(32'h0);
        feed(32'h11);
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_count", 32'(sample_count), 32'd1);
        reset = 1'b1;
        step(); step();
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_triggered", 32'(triggered), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(sample_count), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        reset = 1'b0;
        step();

        // Basic capture; the arm-cycle sample matches the trigger but must be dropped
        trig_value = 32'd3;
        trig_mask  = 32'hFFFF_FFFF;
        do_arm(32'd3);
        feed(32'd1);
        feed(32'd2);
        check("basic_not_trig", 32'(triggered), 32'd0);
        feed(32'd3);
        check("basic_trig", 32'(triggered), 32'd1);
        feed(32'd4);
        check("basic_post_no_valid", 32'(rd_valid), 32'd0);
        feed(32'd5);
        check("basic_rd_valid", 32'(rd_valid), 32'd1);
        check("basic_count", 32'(sample_count), 32'd5);
        for (int v = 1; v <= 5; v++) push(32'(v), 16'd0);
        drain("basic", 0, 0);

        // Wrap-around: 22 samples into 8 entries, the 23rd arrives in READOUT
        trig_value = 32'd20;
        do_arm(32'd0);
        for (int v = 1; v <= 22; v++) feed(32'(v));
        check("wrap_rd_valid", 32'(rd_valid), 32'd1);
        check("wrap_count", 32'(sample_count), 32'd8);
        feed(32'd23);
        check("wrap_count_after_23", 32'(sample_count), 32'd8);
        for (int v = 15; v <= 22; v++) push(32'(v), 16'd0);
        drain("wrap", 0, 0);

        // Gaps in POST and backpressure in READOUT
        trig_value = 32'h30;
        do_arm(32'd0);
        feed(32'h10);
        feed(32'h20);
        feed(32'h30);
        feed(32'h40);
        for (int i = 0; i < 3; i++) begin
            step();
            check("gap_triggered", 32'(triggered), 32'd1);
            check("gap_no_readout", 32'(rd_valid), 32'd0);
        end
        feed(32'h50);
        check("gap_rd_valid", 32'(rd_valid), 32'd1);
        check("gap_count", 32'(sample_count), 32'd5);
        push(32'h10, 16'd0); push(32'h20, 16'd0); push(32'h30, 16'd0);
        push(32'h40, 16'd0); push(32'h50, 16'd0);
        drain("stall", 1, 4);

        // Abort while in POST
        trig_value = 32'd7;
        do_arm(32'd0);
        feed(32'd7);
        check("abort_pre_trig", 32'(triggered), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_valid", 32'(rd_valid), 32'd0);
        check("abort_triggered", 32'(triggered), 32'd0);
        check("abort_count", 32'(sample_count), 32'd1);
        done_before = done_cnt;
        step(); step(); step();
        check("abort_no_done", 32'(done_cnt - done_before), 32'd0);

        // mask=0 triggers on the first sample; arm during READOUT is ignored
        trig_value = 32'h1234;
        trig_mask  = 32'h0;
        do_arm(32'h5555);
        feed(32'hAAAA);
        check("mask0_trig", 32'(triggered), 32'd1);
        feed(32'hBBBB);
        feed(32'hCCCC);
        check("mask0_rd_valid", 32'(rd_valid), 32'd1);
        check("mask0_count", 32'(sample_count), 32'd3);
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("rearm_busy", 32'(busy), 32'd1);
        check("rearm_rd_valid", 32'(rd_valid), 32'd1);
        check("rearm_count", 32'(sample_count), 32'd3);
        push(32'hAAAA, 16'd0); push(32'hBBBB, 16'd0); push(32'hCCCC, 16'd0);
        drain("rearm", 0, 0);

`ifdef MIPS32_TRACE_TSTAMP_EN
        // Edge k after reset writes stamp k-1; arm is edge 1, samples at edges 11, 12, 16
        trig_value = 32'h100;
        trig_mask  = 32'hFFFF_FFFF;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        check("ts_rst_stamp", 32'(rd_tstamp), 32'd0);
        do_arm(32'd0);
        for (int k = 2; k <= 16; k++) begin
            res_valid = (k == 11) || (k == 12) || (k == 16);
            result    = (k == 11) ? 32'h100 : (k == 12) ? 32'h101 : 32'h102;
            step();
        end
        res_valid = 1'b0;
        check("ts_rd_valid", 32'(rd_valid), 32'd1);
        push(32'h100, 16'd10); push(32'h101, 16'd11); push(32'h102, 16'd15);
        drain("tstamp", 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
